decompressor_unit: RTL and testbench
====================================

Name: decompressor_unit

Overview:
- Inverse of the 8-word compressor.
- Accepts a serial 32-bit stream of compressed blocks. Each block is one header word carrying 8 two-bit tags, followed by a variable number of payload words.
- Expands each block into a 256-bit, 8-word output with its tag vector, over a valid/ready interface.
- Sits between the compressed-store read path and the consumer of uncompressed 8-word lines.

Parameters:
- DATA_WIDTH, 32, width of one data word (fixed; only 32 supported).
- NUM_DATA, 8, words per block.
- TAG_WIDTH, 2, tag bits per word.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- inValid  in  1  input word valid.
- inData  in  32  header or payload word.
- inReady  out  1  input word accepted when inValid && inReady.
- outValid  out  1  expanded block valid.
- outReady  in  1  consumer accepts the block when outValid && outReady.
- dataOut  out  256  expanded words; word i is at [32i+31:32i].
- tagOut  out  16  tags of the block; tag i is at [2i+1:2i].
- busy  out  1  high in any state other than HDR.

Behaviour:
- Tag codes:
  - 00 ZERO: word = 0, consumes no payload.
  - 01 REPEAT: word = previously expanded word, consumes no payload.
  - 10 HALF: word = {16'h0, half}, consumes one 16-bit half.
  - 11 FULL: word = one full payload word.
- Header word: inData[15:0] holds the 8 tags; tag i is at [2i+1:2i].
- Half packing:
  - A HALF tag with no buffered half consumes a new word: uses [15:0], buffers [31:16] (halfValid = 1).
  - The next HALF tag in the same block uses the buffered half and clears halfValid.
  - FULL tags always consume a new word and never touch the half buffer.
  - At block end halfValid is cleared; an unused buffered half is discarded.
- FSM states: HDR, EXPAND, OUT.
  - HDR: inReady = 1. On handshake, latch tags, slot = 0, go to EXPAND.
  - EXPAND: processes exactly one slot per cycle in which the slot is resolvable.
    - inReady = 1 only when the current slot needs a new word (FULL, or HALF with halfValid = 0).
    - If a new word is needed and inValid = 0, stall with no state change.
    - After slot 7 resolves, go to OUT.
  - OUT: outValid = 1. dataOut and tagOut are held stable until outReady. On handshake go to HDR.
- Timing: best case, header accepted in cycle T, slots resolve in T+1..T+8, outValid at T+9. Minimum 10 cycles per block.
- prevWord:
  - Updated with each resolved slot value.
  - Persists across blocks: REPEAT in slot 0 yields slot 7 of the previous block.
  - Value is 0 after reset.
- Reset values: inReady = 0 during reset and 1 after (state HDR). outValid = 0, dataOut = 0, tagOut = 0, busy = 0, halfValid = 0, prevWord = 0, slot = 0.
- Reset mid-operation (asynchronous): the partial block is lost. No output is produced for it. The next accepted word is treated as a header.
- outReady asserted outside OUT has no effect.
- Header bits [31:16] are ignored unless the optional feature is enabled.

Optional Feature:
- Macro: DECOMPRESSOR_HDR_CHECK_EN.
- Enabled:
  - Header [31:16] must equal 16'hC0DE.
  - On mismatch: hdrErr output (1 bit, reset 0) pulses high for one cycle, and the word is dropped. State stays HDR and the next word is treated as a header.
  - hdrErrCount output (8 bits) saturates at 255 and is cleared by reset.
- Disabled: the hdrErr and hdrErrCount ports are absent and header [31:16] is ignored.

Decomposition:
- Package decompressor_pkg:
  - Tag constants TAG_ZERO, TAG_REPEAT, TAG_HALF, TAG_FULL.
  - DATA_WIDTH, NUM_DATA, TAG_WIDTH.
  - HDR_MAGIC = 16'hC0DE.
  - FSM state encoding.
- Sub-module decompressor_slot_decode (combinational):
  - Inputs: tag, prevWord, inData, halfBuf, halfValid.
  - Outputs: value, needWord, setHalf, clearHalf.
- Top level holds the FSM, slot counter, half buffer and output register.

Test Plan:
- Header 16'hFFFF, then 8 words 1..8, outReady=1: dataOut = {8,7,...,1}, tagOut = 16'hFFFF, outValid at header cycle + 9.
- Header 16'h0000, no payload: dataOut = 0, 9 cycles after header, inReady low throughout EXPAND.
- Header 16'hAAAA, payload 32'h2222_1111, 32'h4444_3333, 32'h6666_5555, 32'h8888_7777: slots = 32'h1111, 32'h2222, ..., 32'h8888 (zero-extended). Exactly 4 payload words consumed.
- Block with slot7 = 32'hDEADBEEF, then header with all tags 01: every word = 32'hDEADBEEF. Tags 10,11,10 (slots 0-2, others 00) with payload 32'hBBBB_AAAA, 32'h1234_5678: slot0 = 32'hAAAA, slot1 = 32'h1234_5678, slot2 = 32'hBBBB.
- Backpressure: hold outReady=0 for 5 cycles in OUT: dataOut stable, inReady=0. Drop inValid mid-EXPAND: slot stalls, no corruption.
- reset low mid-EXPAND (slot 4): outputs go to reset values immediately. The next word is treated as a header; with DECOMPRESSOR_HDR_CHECK_EN, a header with [31:16] = 16'h1234 gives a hdrErr pulse and hdrErrCount = 1.

Source files
------------

// File: rtl/decompressor_pkg.sv
// Shared widths, tag codes, FSM encoding and helpers for the 8-word block decompressor.
// DECOMPRESSOR_HDR_CHECK_EN enables header magic checking in decompressor_unit.
package decompressor_pkg;

    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned NUM_DATA        = 8;
    localparam int unsigned TAG_WIDTH       = 2;
    localparam int unsigned HALF_WIDTH      = DATA_WIDTH / 2;
    localparam int unsigned SLOT_WIDTH      = $clog2(NUM_DATA);
    localparam int unsigned BLOCK_WIDTH     = DATA_WIDTH * NUM_DATA;
    localparam int unsigned TAGS_WIDTH      = TAG_WIDTH * NUM_DATA;
    localparam int unsigned ERR_COUNT_WIDTH = 8;

    localparam logic [TAG_WIDTH-1:0] TAG_ZERO   = 2'b00;
    localparam logic [TAG_WIDTH-1:0] TAG_REPEAT = 2'b01;
    localparam logic [TAG_WIDTH-1:0] TAG_HALF   = 2'b10;
    localparam logic [TAG_WIDTH-1:0] TAG_FULL   = 2'b11;

    localparam logic [HALF_WIDTH-1:0] HDR_MAGIC = 16'hC0DE;

    typedef enum logic [1:0] {
        HDR    = 2'd0,
        EXPAND = 2'd1,
        OUT    = 2'd2
    } fsmState_t;

    // A slot pulls a fresh input word for FULL, or for HALF when no half is buffered.
    function automatic logic needsWord(input logic [TAG_WIDTH-1:0] tag, input logic halfValid);
        return (tag == TAG_FULL) || ((tag == TAG_HALF) && !halfValid);
    endfunction

endpackage

// File: rtl/decompressor_if.sv
// Stream-in / block-out handshake bundle of the decompressor.
interface decompressor_if;
    import decompressor_pkg::*;

    logic                   inValid;
    logic [DATA_WIDTH-1:0]  inData;
    logic                   inReady;
    logic                   outValid;
    logic                   outReady;
    logic [BLOCK_WIDTH-1:0] dataOut;
    logic [TAGS_WIDTH-1:0]  tagOut;
    logic                   busy;

    modport master (
        input  inValid, inData, outReady,
        output inReady, outValid, dataOut, tagOut, busy
    );

    modport slave (
        output inValid, inData, outReady,
        input  inReady, outValid, dataOut, tagOut, busy
    );

endinterface

// File: rtl/decompressor_slot_decode.sv
// Combinational resolution of one slot's tag into its expanded word and half-buffer actions.
module decompressor_slot_decode
    import decompressor_pkg::*;
(
    input  logic [TAG_WIDTH-1:0]  tag,
    input  logic [DATA_WIDTH-1:0] prevWord,
    input  logic [DATA_WIDTH-1:0] inData,
    input  logic [HALF_WIDTH-1:0] halfBuf,
    input  logic                  halfValid,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  needWord,
    output logic                  setHalf,
    output logic                  clearHalf
);

    always_comb begin
        value     = '0;
        setHalf   = 1'b0;
        clearHalf = 1'b0;
        needWord  = needsWord(tag, halfValid);
        case (tag)
            TAG_ZERO:   value = '0;
            TAG_REPEAT: value = prevWord;
            TAG_HALF: begin
                if (halfValid) begin
                    value     = DATA_WIDTH'(halfBuf);
                    clearHalf = 1'b1;
                end else begin
                    value   = DATA_WIDTH'(inData[HALF_WIDTH-1:0]);
                    setHalf = 1'b1;
                end
            end
            default:    value = inData;
        endcase
    end

endmodule

// File: rtl/decompressor_unit.sv
// Expands a serial stream of tagged compressed blocks into 8-word lines.
// Define DECOMPRESSOR_HDR_CHECK_EN to reject headers whose upper half is not HDR_MAGIC.
module decompressor_unit
    import decompressor_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
`ifdef DECOMPRESSOR_HDR_CHECK_EN
    output logic                       hdrErr,
    output logic [ERR_COUNT_WIDTH-1:0] hdrErrCount,
`endif
    decompressor_if.master             bus
);

    fsmState_t              state, stateNext;
    logic [SLOT_WIDTH-1:0]  slot, slotNext;
    logic [TAGS_WIDTH-1:0]  tags, tagsNext;
    logic [BLOCK_WIDTH-1:0] words, wordsNext;
    logic [DATA_WIDTH-1:0]  prevWord, prevWordNext;
    logic [HALF_WIDTH-1:0]  halfBuf, halfBufNext;
    logic                   halfValid, halfValidNext;
    logic                   inReadyQ, inReadyNext;
    logic                   outValidQ, outValidNext;
    logic                   busyQ, busyNext;
    logic [TAG_WIDTH-1:0]   curTag, nextTag;
    logic [DATA_WIDTH-1:0]  slotValue;
    logic                   needWord, setHalf, clearHalf;
    logic                   inFire;

`ifdef DECOMPRESSOR_HDR_CHECK_EN
    logic                       hdrErrQ, hdrErrNext;
    logic [ERR_COUNT_WIDTH-1:0] errCount, errCountNext;
`endif

    assign curTag = tags[32'(slot) * TAG_WIDTH +: TAG_WIDTH];
    assign inFire = bus.inValid && inReadyQ;

    decompressor_slot_decode slotDecode (
        .tag       (curTag),
        .prevWord  (prevWord),
        .inData    (bus.inData),
        .halfBuf   (halfBuf),
        .halfValid (halfValid),
        .value     (slotValue),
        .needWord  (needWord),
        .setHalf   (setHalf),
        .clearHalf (clearHalf)
    );

    // Next-state and next-output logic; inReady is precomputed for the following cycle.
    always_comb begin
        stateNext     = state;
        slotNext      = slot;
        tagsNext      = tags;
        wordsNext     = words;
        prevWordNext  = prevWord;
        halfBufNext   = halfBuf;
        halfValidNext = halfValid;
`ifdef DECOMPRESSOR_HDR_CHECK_EN
        hdrErrNext    = 1'b0;
        errCountNext  = errCount;
`endif
        case (state)
            HDR: begin
                if (inFire) begin
`ifdef DECOMPRESSOR_HDR_CHECK_EN
                    if (bus.inData[DATA_WIDTH-1 -: HALF_WIDTH] != HDR_MAGIC) begin
                        hdrErrNext = 1'b1;
                        if (errCount != '1) begin
                            errCountNext = errCount + ERR_COUNT_WIDTH'(1);
                        end
                    end else
`endif
                    begin
                        tagsNext      = bus.inData[TAGS_WIDTH-1:0];
                        slotNext      = '0;
                        halfValidNext = 1'b0;
                        stateNext     = EXPAND;
                    end
                end
            end
            EXPAND: begin
                if (!needWord || inFire) begin
                    wordsNext[32'(slot) * DATA_WIDTH +: DATA_WIDTH] = slotValue;
                    prevWordNext = slotValue;
                    if (setHalf) begin
                        halfBufNext   = bus.inData[DATA_WIDTH-1 -: HALF_WIDTH];
                        halfValidNext = 1'b1;
                    end
                    if (clearHalf) begin
                        halfValidNext = 1'b0;
                    end
                    // Leftover buffered half is dropped at the end of the block.
                    if (slot == SLOT_WIDTH'(NUM_DATA - 1)) begin
                        slotNext      = '0;
                        halfValidNext = 1'b0;
                        stateNext     = OUT;
                    end else begin
                        slotNext = slot + SLOT_WIDTH'(1);
                    end
                end
            end
            OUT: begin
                if (bus.outReady) begin
                    stateNext = HDR;
                end
            end
            default: stateNext = HDR;
        endcase

        nextTag = tagsNext[32'(slotNext) * TAG_WIDTH +: TAG_WIDTH];
        case (stateNext)
            HDR:     inReadyNext = 1'b1;
            EXPAND:  inReadyNext = needsWord(nextTag, halfValidNext);
            default: inReadyNext = 1'b0;
        endcase
        outValidNext = (stateNext == OUT);
        busyNext     = (stateNext != HDR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HDR;
            slot      <= '0;
            tags      <= '0;
            words     <= '0;
            prevWord  <= '0;
            halfBuf   <= '0;
            halfValid <= 1'b0;
            inReadyQ  <= 1'b0;
            outValidQ <= 1'b0;
            busyQ     <= 1'b0;
`ifdef DECOMPRESSOR_HDR_CHECK_EN
            hdrErrQ   <= 1'b0;
            errCount  <= '0;
`endif
        end else begin
            state     <= stateNext;
            slot      <= slotNext;
            tags      <= tagsNext;
            words     <= wordsNext;
            prevWord  <= prevWordNext;
            halfBuf   <= halfBufNext;
            halfValid <= halfValidNext;
            inReadyQ  <= inReadyNext;
            outValidQ <= outValidNext;
            busyQ     <= busyNext;
`ifdef DECOMPRESSOR_HDR_CHECK_EN
            hdrErrQ   <= hdrErrNext;
            errCount  <= errCountNext;
`endif
        end
    end

    assign bus.inReady  = inReadyQ;
    assign bus.outValid = outValidQ;
    assign bus.dataOut  = words;
    assign bus.tagOut   = tags;
    assign bus.busy     = busyQ;
`ifdef DECOMPRESSOR_HDR_CHECK_EN
    assign hdrErr       = hdrErrQ;
    assign hdrErrCount  = errCount;
`endif

endmodule

// File: tb/tb_decompressor_unit.sv
// Randomized self-checking bench for decompressor_unit against a block-level reference model.
module tb_decompressor_unit;
    import decompressor_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decompressor_if bus ();

`ifdef DECOMPRESSOR_HDR_CHECK_EN
    logic       hdrErr;
    logic [7:0] hdrErrCount;
`endif

    decompressor_unit dut (
        .clk         (clk),
        .reset       (reset),
`ifdef DECOMPRESSOR_HDR_CHECK_EN
        .hdrErr      (hdrErr),
        .hdrErrCount (hdrErrCount),
`endif
        .bus         (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]  inQ[$];
    bit           hdrQ[$];
    logic [255:0] expData[$];
    logic [15:0]  expTag[$];
    int           expCnt[$];
    logic [31:0]  fixedPay[$];
    logic [31:0]  modelPrev = '0;

    task automatic checkVal(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] nextPay();
        if (fixedPay.size() > 0) return fixedPay.pop_front();
        return $urandom;
    endfunction

    function automatic logic [15:0] hdrHi();
`ifdef DECOMPRESSOR_HDR_CHECK_EN
        return 16'hC0DE;
`else
        return 16'($urandom);
`endif
    endfunction

    // Reference model: expand one block from its tags, drawing payload words as the rules demand.
    task automatic buildBlock(input logic [15:0] tags);
        logic [255:0] d;
        logic [31:0]  pay[$];
        logic [31:0]  w, v;
        logic [15:0]  pend;
        bit           havePend;
        d = '0; pend = '0; havePend = 0;
        for (int i = 0; i < 8; i++) begin
            case (tags[2*i +: 2])
                2'b00: v = 32'h0;
                2'b01: v = modelPrev;
                2'b10: begin
                    if (havePend) begin
                        v = {16'h0, pend};
                        havePend = 0;
                    end else begin
                        w = nextPay();
                        pay.push_back(w);
                        v = {16'h0, w[15:0]};
                        pend = w[31:16];
                        havePend = 1;
                    end
                end
                default: begin
                    w = nextPay();
                    pay.push_back(w);
                    v = w;
                end
            endcase
            d[32*i +: 32] = v;
            modelPrev = v;
        end
        inQ.push_back({hdrHi(), tags});
        hdrQ.push_back(1'b1);
        foreach (pay[k]) begin
            inQ.push_back(pay[k]);
            hdrQ.push_back(1'b0);
        end
        expData.push_back(d);
        expTag.push_back(tags);
        expCnt.push_back(pay.size());
    endtask

    task automatic driveInputs(input int validPct, input int readyPct);
        bus.inValid  = (inQ.size() > 0) && ($urandom_range(99) < validPct);
        bus.inData   = (inQ.size() > 0) ? inQ[0] : $urandom;
        bus.outReady = ($urandom_range(99) < readyPct);
    endtask

    // Feed queued words, consume blocks and compare; latency is checked only in full-rate runs.
    task automatic runEngine(input int validPct, input int readyPct, input bit checkLat, input int budget);
        bit           inAcc, outAcc, inOut, prevHold;
        logic [255:0] prevData;
        int           hdrCyc, payCount;
        inOut = 0; prevHold = 0; prevData = '0; hdrCyc = 0; payCount = 0;
        @(posedge clk); #1;
        driveInputs(validPct, readyPct);
        for (int cyc = 0; cyc < budget && (inQ.size() > 0 || expData.size() > 0); cyc++) begin
            @(negedge clk);
`ifdef DECOMPRESSOR_HDR_CHECK_EN
            checkVal("hdrErrIdle", 256'(hdrErr), 256'(0));
`endif
            if (prevHold) begin
                checkVal("holdData", bus.dataOut, prevData);
                checkVal("holdValid", 256'(bus.outValid), 256'(1));
            end
            if (bus.outValid) begin
                checkVal("outInReady", 256'(bus.inReady), 256'(0));
                checkVal("outBusy", 256'(bus.busy), 256'(1));
                if (!inOut) begin
                    inOut = 1;
                    checkVal("outPending", 256'(expData.size() > 0), 256'(1));
                    if (expData.size() > 0) begin
                        checkVal("payCount", 256'(payCount), 256'(expCnt[0]));
                        if (checkLat) checkVal("latency", 256'(cyc - hdrCyc), 256'(9));
                    end
                end
            end
            inAcc  = bus.inValid && bus.inReady;
            outAcc = bus.outValid && bus.outReady;
            if (outAcc && expData.size() > 0) begin
                checkVal("dataOut", bus.dataOut, expData[0]);
                checkVal("tagOut", 256'(bus.tagOut), 256'(expTag[0]));
                void'(expData.pop_front());
                void'(expTag.pop_front());
                void'(expCnt.pop_front());
                inOut = 0;
            end
            prevHold = bus.outValid && !bus.outReady;
            prevData = bus.dataOut;
            if (inAcc) begin
                if (hdrQ[0]) begin
                    hdrCyc = cyc;
                    payCount = 0;
                end else begin
                    payCount++;
                end
            end
            @(posedge clk); #1;
            if (inAcc) begin
                void'(inQ.pop_front());
                void'(hdrQ.pop_front());
            end
            driveInputs(validPct, readyPct);
        end
        checkVal("timeout", 256'(expData.size() + inQ.size()), 256'(0));
        bus.inValid = 1'b0;
    endtask

    initial begin
        int acc;
        reset = 1'b0;
        bus.inValid = 1'b0;
        bus.inData = '0;
        bus.outReady = 1'b0;
        #12;
        checkVal("rstInReady", 256'(bus.inReady), 256'(0));
        checkVal("rstOutValid", 256'(bus.outValid), 256'(0));
        checkVal("rstDataOut", bus.dataOut, 256'(0));
        checkVal("rstTagOut", 256'(bus.tagOut), 256'(0));
        checkVal("rstBusy", 256'(bus.busy), 256'(0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkVal("idleInReady", 256'(bus.inReady), 256'(1));

        // Directed blocks at full rate with immediate consumption.
        for (int i = 1; i <= 8; i++) fixedPay.push_back(32'(i));
        buildBlock(16'hFFFF);
        buildBlock(16'h0000);
        fixedPay = '{32'h2222_1111, 32'h4444_3333, 32'h6666_5555, 32'h8888_7777};
        buildBlock(16'hAAAA);
        fixedPay.push_back(32'hDEADBEEF);
        buildBlock(16'hC000);
        buildBlock(16'h5555);
        fixedPay = '{32'hBBBB_AAAA, 32'h1234_5678};
        buildBlock(16'h002E);
        checkVal("modelHalfPack", expData[5][95:0], {32'h0000_BBBB, 32'h1234_5678, 32'h0000_AAAA});
        runEngine(100, 100, 1'b1, 500);

        // Heavy backpressure and input gaps.
        for (int b = 0; b < 6; b++) buildBlock(16'($urandom));
        runEngine(50, 15, 1'b0, 3000);

        // Reset while slot 4 is pending.
        @(posedge clk); #1;
        bus.outReady = 1'b1;
        bus.inValid = 1'b1;
        bus.inData = {hdrHi(), 16'hFFFF};
        acc = 0;
        for (int c = 0; c < 50 && acc < 5; c++) begin
            @(negedge clk);
            if (bus.inValid && bus.inReady) acc++;
            @(posedge clk); #1;
            bus.inData = $urandom;
        end
        checkVal("rstSetup", 256'(acc), 256'(5));
        checkVal("busyExpand", 256'(bus.busy), 256'(1));
        bus.inValid = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkVal("midRstInReady", 256'(bus.inReady), 256'(0));
        checkVal("midRstOutValid", 256'(bus.outValid), 256'(0));
        checkVal("midRstBusy", 256'(bus.busy), 256'(0));
        checkVal("midRstDataOut", bus.dataOut, 256'(0));
        checkVal("midRstTagOut", 256'(bus.tagOut), 256'(0));
        modelPrev = '0;
        @(negedge clk);
        reset = 1'b1;

`ifdef DECOMPRESSOR_HDR_CHECK_EN
        checkVal("rstErrCount", 256'(hdrErrCount), 256'(0));
        @(posedge clk); #1;
        bus.inData = {16'h1234, 16'hFFFF};
        bus.inValid = 1'b1;
        acc = 0;
        for (int c = 0; c < 20 && acc == 0; c++) begin
            @(negedge clk);
            acc = (bus.inValid && bus.inReady) ? 1 : 0;
            if (acc == 0) begin
                @(posedge clk); #1;
            end
        end
        checkVal("badHdrTaken", 256'(acc), 256'(1));
        @(posedge clk); #1;
        bus.inValid = 1'b0;
        @(negedge clk);
        checkVal("hdrErrPulse", 256'(hdrErr), 256'(1));
        checkVal("hdrErrCount", 256'(hdrErrCount), 256'(1));
        checkVal("badHdrBusy", 256'(bus.busy), 256'(0));
        checkVal("badHdrInReady", 256'(bus.inReady), 256'(1));
        @(negedge clk);
        checkVal("hdrErrClear", 256'(hdrErr), 256'(0));
`endif

        // First block after reset: REPEAT must see a cleared previous word.
        buildBlock(16'h5555);
        runEngine(100, 100, 1'b1, 200);

        // Randomized traffic in several rate mixes.
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < 10; b++) buildBlock(16'($urandom));
            case (r)
                0:       runEngine(100, 100, 1'b1, 4000);
                1:       runEngine(70, 60, 1'b0, 4000);
                2:       runEngine(30, 90, 1'b0, 4000);
                default: runEngine(85, 25, 1'b0, 4000);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
